// File: rtl/pending_req_encoder16.sv
// Captures request events on 16 lines into a sticky pending register and
// serialises them, highest index first, as 4-bit codes over valid/ready.
module pending_req_encoder16 #(
  parameter bit EDGE  = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      req_in,
  input  logic [15:0]      mask,
  output logic [3:0]       code_out,
  output logic             valid,
  input  logic             ready,
  output logic [15:0]      pending,
  output logic             any_pend,
  output logic [CNT_W-1:0] lost_cnt
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state, state_next;
  logic [15:0] req_d, rise, ev, clr, pend_next, elig;
  logic [3:0]  sel;
  logic        accept, lost_hit;

  assign rise      = req_in & ~req_d;
  assign ev        = EDGE ? rise : req_in;
  assign accept    = (state == PRESENT) && ready;
  assign clr       = accept ? (16'h0001 << code_out) : 16'h0000;
  assign pend_next = (pending & ~clr) | ev;
  assign elig      = pending & ~mask;
  assign valid     = (state == PRESENT);

  // Losses are judged on fresh rising edges so a line held high in level
  // mode keeps its bit pending without inflating the counter.
  assign lost_hit  = |(rise & pending & ~clr);

  always_comb begin
    sel = 4'd0;
    for (int i = 0; i < 16; i++)
      if (elig[i]) sel = 4'(i);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|elig) state_next = PRESENT;
      PRESENT: if (ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d    <= '0;
      pending  <= '0;
      any_pend <= 1'b0;
      code_out <= '0;
      lost_cnt <= '0;
    end else begin
      req_d    <= req_in;
      pending  <= pend_next;
      any_pend <= |(pend_next & ~mask);
      // code_out only moves when a new presentation starts; held otherwise
      if (state == IDLE && |elig) code_out <= sel;
      if (lost_hit && lost_cnt != {CNT_W{1'b1}}) lost_cnt <= lost_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pending_req_encoder16.md
Name: pending_req_encoder16

Overview:
- Registered capture-and-serialise stage for 16 request lines.
- Detects request events and holds them in a sticky pending register.
- Each accepted transfer carries one 4-bit index, chosen by highest-index-first priority, over a valid/ready handshake.
- Sits directly upstream of the combinational 16-to-4 encoder path. It turns asynchronous-rate, possibly simultaneous requests into a stable, one-at-a-time encoded stream with loss accounting.

Parameters:
- EDGE, 1: 1 = a pending bit is set on a rising edge of req_in[i]; 0 = it is set while req_in[i] is high (level).
- CNT_W, 8: width of the saturating lost-event counter.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- req_in  input  16  raw request lines, synchronous to clk.
- mask  input  16  1 = bit i is excluded from selection; it still captures and stays pending.
- code_out  output  4  encoded index of the presented request.
- valid  output  1  code_out holds a request.
- ready  input  1  consumer accepts when valid && ready.
- pending  output  16  current sticky pending register.
- any_pend  output  1  OR of (pending & ~mask), registered form of the group-enable.
- lost_cnt  output  CNT_W  saturating count of events that hit an already-pending bit.

Behaviour:
- Reset (asynchronous, active-high): outputs and internal state go to the following values immediately.
  - code_out=0, valid=0, pending=0, any_pend=0, lost_cnt=0.
  - req_d (previous req_in sample) = 0.
  - FSM = IDLE.
- Event detect:
  - EDGE=1: ev[i] = req_in[i] & ~req_d[i]; req_d is registered every cycle.
  - EDGE=0: ev[i] = req_in[i].
- Pending update, every clock: pending_next = (pending & ~clr) | ev.
  - clr is a one-hot of code_out on an accept cycle; otherwise 0.
  - Set wins over clear: if ev[k] coincides with the accept of index k, bit k stays pending (new event, not lost).
- Lost events:
  - Condition: ev[i]=1 while pending[i]=1 and the bit is not being cleared that cycle.
  - Response: lost_cnt increments by 1 per cycle in which this holds for at least one bit; multiple bits in the same cycle still count 1.
  - lost_cnt saturates at all-ones. In EDGE=0 a held-high line does not count as lost.
- Selection: sel = highest i with (pending[i] & ~mask[i]), computed from the registered pending.
- any_pend is registered as OR(pending_next & ~mask).
- FSM:
  - IDLE: if any bit satisfies pending & ~mask, latch code_out=sel, assert valid next cycle → PRESENT. Otherwise stay.
  - PRESENT: valid=1, and code_out is held stable even if pending/mask change.
    - On valid&&ready: clear pending[code_out] (subject to set-wins), drop valid → IDLE.
    - No back-to-back presentation; minimum 2 cycles per transfer.
    - A mask change on the presented index does not withdraw it.
- Latency (EDGE=1, idle, unmasked):
  - Edge visible on req_in at the clk edge of cycle N → pending set at N+1 → valid=1 with code_out at N+2.
- Simultaneous events on bits 3 and 12: 12 is served first, then 3.
- Mask: masked pending bits are never selected and never counted in any_pend. Unmasking makes them eligible on the next IDLE evaluation.
- All-masked or empty: FSM stays IDLE, valid=0, and code_out keeps its last value.
- Reset mid-transfer: valid drops immediately and pending is lost; no partial state survives.
- ready while valid=0 is ignored.

Test Plan:
- Reset, then a single rising edge on req_in[5] at cycle N with ready=1 → valid=1, code_out=5 at N+2; accepted; pending=0 and valid=0 at N+3.
- Same-cycle edges on bits 3, 9, 15 with ready=1 → accepted codes in order 15, 9, 3. Each transfer takes 2 cycles. lost_cnt=0.
- ready=0 while presenting code 7, then rise bit 10 and mask bit 7 → code_out stays 7 and valid stays 1. Raise ready → 7 accepted, then 10 presented.
- Second rising edge on bit 2 while pending[2]=1 and not accepted → lost_cnt=1. Drive 300 such collisions with CNT_W=8 → lost_cnt=255.
- Edge on bit 4 in the same cycle its accept occurs → pending[4] stays 1, lost_cnt unchanged, code 4 re-presented.
- mask=16'hFFFF with pending=16'h0081 → valid=0 and any_pend=0. Clear mask → code 7, then code 0. Assert rst while valid=1 → valid, pending, lost_cnt read 0 before the next clk edge.
